// File: rtl/branch_predictor.sv
// Dynamic branch predictor: direct-mapped BTB plus saturating counter table,
// bimodal or gshare indexed, with an init sweep after reset and saturating stats.
module branch_predictor #(
    parameter int ENTRIES = 64,
    parameter int ADDR_W  = 32,
    parameter int CTR_W   = 2,
    parameter int MODE    = 0,
    parameter int GHR_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    output logic              ready,
    input  logic              lk_valid,
    input  logic [ADDR_W-1:0] lk_pc,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_target,
    output logic [GHR_W-1:0]  pred_ghr,
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic              upd_cond,
    input  logic              upd_taken,
    input  logic [ADDR_W-1:0] upd_target,
    input  logic [GHR_W-1:0]  upd_ghr,
    input  logic              upd_mispredict,
    output logic [31:0]       stat_lookups,
    output logic [31:0]       stat_mispredicts
);

    localparam int IW    = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - IW - 2;
    localparam logic [CTR_W-1:0] CTR_MAX = '1;
    localparam logic [CTR_W-1:0] CTR_WNT = CTR_W'((1 << (CTR_W - 1)) - 1);

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t         state_q, state_d;
    logic [IW-1:0]  ptr_q;
    logic [GHR_W-1:0] ghr_q;

    logic              valid_mem [ENTRIES];
    logic [TAG_W-1:0]  tag_mem   [ENTRIES];
    logic [ADDR_W-1:0] tgt_mem   [ENTRIES];
    logic [CTR_W-1:0]  ctr_mem   [ENTRIES];

    logic [IW-1:0]    lk_idx, lk_cidx;
    logic [TAG_W-1:0] lk_tag;
    logic [CTR_W-1:0] lk_ctr;

    logic [IW-1:0]    upd_idx, upd_cidx;
    logic [TAG_W-1:0] upd_tag;
    logic [CTR_W-1:0] ctr_cur, ctr_nxt;
    logic             upd_en;
    logic [GHR_W:0]   ghr_shift;

    logic unused_pc_bits;
    assign unused_pc_bits = ^{lk_pc[1:0], upd_pc[1:0]};

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_INIT;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_INIT)
                ptr_q <= ptr_q + IW'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_INIT:  if (ptr_q == IW'(ENTRIES - 1)) state_d = S_RUN;
            S_RUN:   state_d = S_RUN;
            default: state_d = S_INIT;
        endcase
    end

    assign ready = (state_q == S_RUN);

    // ---------------- Lookup (combinational) ----------------
    always_comb begin
        lk_idx  = lk_pc[IW+1:2];
        lk_tag  = lk_pc[ADDR_W-1:IW+2];
        lk_cidx = (MODE == 1) ? (lk_idx ^ IW'(ghr_q)) : lk_idx;
        lk_ctr  = ctr_mem[lk_cidx];
        pred_hit    = ready & lk_valid & valid_mem[lk_idx] & (tag_mem[lk_idx] == lk_tag);
        pred_taken  = pred_hit & lk_ctr[CTR_W-1];
        pred_target = pred_hit ? tgt_mem[lk_idx] : (lk_pc + ADDR_W'(4));
    end

    assign pred_ghr = ghr_q;

    // ---------------- Update ----------------
    // Counter index uses the history carried with the instruction, not the live ghr.
    always_comb begin
        upd_en   = ready & upd_valid;
        upd_idx  = upd_pc[IW+1:2];
        upd_tag  = upd_pc[ADDR_W-1:IW+2];
        upd_cidx = (MODE == 1) ? (upd_idx ^ IW'(upd_ghr)) : upd_idx;
        ctr_cur  = ctr_mem[upd_cidx];
        ctr_nxt  = ctr_cur;
        if (!upd_cond)
            ctr_nxt = CTR_MAX;
        else if (upd_taken)
            ctr_nxt = (ctr_cur == CTR_MAX) ? ctr_cur : ctr_cur + CTR_W'(1);
        else
            ctr_nxt = (ctr_cur == '0) ? ctr_cur : ctr_cur - CTR_W'(1);
        ghr_shift = {ghr_q, upd_taken};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == S_INIT) begin
                valid_mem[ptr_q] <= 1'b0;
                ctr_mem[ptr_q]   <= CTR_WNT;
            end else if (upd_en) begin
                ctr_mem[upd_cidx] <= ctr_nxt;
                if (upd_taken) begin
                    valid_mem[upd_idx] <= 1'b1;
                    tag_mem[upd_idx]   <= upd_tag;
                    tgt_mem[upd_idx]   <= upd_target;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            ghr_q <= '0;
        else if (upd_en && (MODE == 1) && upd_cond)
            ghr_q <= ghr_shift[GHR_W-1:0];
    end

    // ---------------- Statistics ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_lookups     <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (ready && lk_valid && (stat_lookups != '1))
                stat_lookups <= stat_lookups + 32'd1;
            if (upd_en && upd_mispredict && (stat_mispredicts != '1))
                stat_mispredicts <= stat_mispredicts + 32'd1;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench: a bimodal and a gshare instance (ENTRIES=16) share stimulus.
module tb_branch_predictor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b0;
    logic        lk_valid = 1'b0;
    logic [31:0] lk_pc = '0;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = '0;
    logic        upd_cond = 1'b0;
    logic        upd_taken = 1'b0;
    logic [31:0] upd_target = '0;
    logic [3:0]  upd_ghr = '0;
    logic        upd_mispredict = 1'b0;

    logic        ready0, hit0, taken0, ready1, hit1, taken1;
    logic [31:0] target0, target1, sl0, sm0, sl1, sm1;
    logic [3:0]  ghr0, ghr1;

    branch_predictor #(.ENTRIES(16), .ADDR_W(32), .CTR_W(2), .MODE(0), .GHR_W(4)) dut0 (
        .clk(clk), .rst(rst), .ready(ready0), .lk_valid(lk_valid), .lk_pc(lk_pc),
        .pred_hit(hit0), .pred_taken(taken0), .pred_target(target0), .pred_ghr(ghr0),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_cond(upd_cond), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_ghr(upd_ghr), .upd_mispredict(upd_mispredict),
        .stat_lookups(sl0), .stat_mispredicts(sm0));

    branch_predictor #(.ENTRIES(16), .ADDR_W(32), .CTR_W(2), .MODE(1), .GHR_W(4)) dut1 (
        .clk(clk), .rst(rst), .ready(ready1), .lk_valid(lk_valid), .lk_pc(lk_pc),
        .pred_hit(hit1), .pred_taken(taken1), .pred_target(target1), .pred_ghr(ghr1),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_cond(upd_cond), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_ghr(upd_ghr), .upd_mispredict(upd_mispredict),
        .stat_lookups(sl1), .stat_mispredicts(sm1));

    typedef struct {
        logic        lkv;
        logic [31:0] lpc;
        logic        uv;
        logic [31:0] upc;
        logic        uc;
        logic        ut;
        logic [31:0] utgt;
        logic        umis;
        logic        eh;
        logic        et;
        logic [31:0] etgt;
    } vec_t;

    typedef struct {
        int          id;
        logic        h;
        logic        t;
        logic [31:0] tg;
    } exp_t;

    vec_t vecs[18];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic pulse_rst();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Counts negedge samples with ready0 low, starting just after the reset edge.
    task automatic count_init(output int n);
        n = 0;
        while (ready0 === 1'b0 && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic upd(input logic [31:0] pc, input logic c, input logic t,
                       input logic [31:0] tg, input logic [3:0] g);
        @(negedge clk);
        upd_valid = 1'b1; upd_pc = pc; upd_cond = c; upd_taken = t;
        upd_target = tg; upd_ghr = g; upd_mispredict = 1'b0;
        @(negedge clk);
        upd_valid = 1'b0;
    endtask

    task automatic look1(input string name, input logic [31:0] pc, input logic eh,
                         input logic et, input logic [31:0] etg);
        @(negedge clk);
        lk_valid = 1'b1; lk_pc = pc;
        #1;
        chk({name, "_hit"}, 32'(hit1), 32'(eh));
        chk({name, "_taken"}, 32'(taken1), 32'(et));
        chk({name, "_target"}, target1, etg);
        lk_valid = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        int   n;
        exp_t e;

        //            lkv lpc    uv upc    uc ut utgt   mis  eh et etgt
        vecs[0]  = '{1, 32'h40, 1, 32'h40, 1, 1, 32'h80, 1, 0, 0, 32'h44};
        vecs[1]  = '{1, 32'h40, 0, 32'h0,  0, 0, 32'h0,  0, 1, 1, 32'h80};
        vecs[2]  = '{1, 32'h40, 1, 32'h40, 1, 1, 32'h80, 0, 1, 1, 32'h80};
        vecs[3]  = '{1, 32'h40, 1, 32'h40, 1, 1, 32'h80, 0, 1, 1, 32'h80};
        vecs[4]  = '{1, 32'h40, 1, 32'h40, 1, 1, 32'h80, 0, 1, 1, 32'h80};
        vecs[5]  = '{1, 32'h40, 1, 32'h40, 1, 0, 32'h0,  0, 1, 1, 32'h80};
        vecs[6]  = '{1, 32'h40, 0, 32'h0,  0, 0, 32'h0,  0, 1, 1, 32'h80};
        vecs[7]  = '{1, 32'h40, 1, 32'h40, 1, 0, 32'h0,  1, 1, 1, 32'h80};
        vecs[8]  = '{1, 32'h40, 0, 32'h0,  0, 0, 32'h0,  0, 1, 0, 32'h80};
        vecs[9]  = '{1, 32'h80, 0, 32'h0,  0, 0, 32'h0,  0, 0, 0, 32'h84};
        vecs[10] = '{1, 32'h80, 1, 32'h80, 1, 1, 32'h100, 1, 0, 0, 32'h84};
        vecs[11] = '{1, 32'h40, 0, 32'h0,  0, 0, 32'h0,  0, 0, 0, 32'h44};
        vecs[12] = '{1, 32'h80, 0, 32'h0,  0, 0, 32'h0,  0, 1, 1, 32'h100};
        vecs[13] = '{1, 32'h44, 1, 32'h44, 0, 1, 32'h200, 0, 0, 0, 32'h48};
        vecs[14] = '{1, 32'h44, 0, 32'h0,  0, 0, 32'h0,  0, 1, 1, 32'h200};
        vecs[15] = '{1, 32'h48, 1, 32'h48, 1, 0, 32'h0,  0, 0, 0, 32'h4c};
        vecs[16] = '{1, 32'h48, 0, 32'h0,  0, 0, 32'h0,  0, 0, 0, 32'h4c};
        vecs[17] = '{0, 32'h80, 0, 32'h0,  0, 0, 32'h0,  0, 0, 0, 32'h84};

        // Reset with a lookup held throughout INIT
        lk_valid = 1'b1; lk_pc = 32'h40;
        pulse_rst();
        chk("rst_ghr", 32'(ghr1), 32'h0);
        n = 0;
        while (ready0 === 1'b0 && n < 200) begin
            if (n == 5) begin
                chk("init_hit", 32'(hit0), 32'h0);
                chk("init_taken", 32'(taken0), 32'h0);
                chk("init_target", target0, 32'h44);
            end
            n++;
            @(negedge clk);
        end
        lk_valid = 1'b0;
        chk("init_len", n, 16);
        chk("init_lookups", sl0, 32'h0);
        chk("init_ready1", 32'(ready1), 32'h1);

        // Reset re-asserted mid-INIT restarts the sweep
        pulse_rst();
        repeat (8) @(negedge clk);
        chk("midinit_ready", 32'(ready0), 32'h0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        count_init(n);
        chk("midinit_len", n, 16);

        // Table-driven bimodal sequence on dut0
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            lk_valid = vecs[i].lkv; lk_pc = vecs[i].lpc;
            upd_valid = vecs[i].uv; upd_pc = vecs[i].upc; upd_cond = vecs[i].uc;
            upd_taken = vecs[i].ut; upd_target = vecs[i].utgt;
            upd_mispredict = vecs[i].umis; upd_ghr = '0;
            sb.push_back('{i, vecs[i].eh, vecs[i].et, vecs[i].etgt});
            #1;
            e = sb.pop_front();
            chk($sformatf("vec%0d_hit", e.id), 32'(hit0), 32'(e.h));
            chk($sformatf("vec%0d_taken", e.id), 32'(taken0), 32'(e.t));
            chk($sformatf("vec%0d_target", e.id), target0, e.tg);
        end
        @(negedge clk);
        lk_valid = 1'b0; upd_valid = 1'b0; upd_mispredict = 1'b0;
        chk("stat_lookups", sl0, 32'd17);
        chk("stat_mispredicts", sm0, 32'd3);

        // Reset clears trained contents and statistics
        pulse_rst();
        count_init(n);
        chk("rerst_len", n, 16);
        @(negedge clk);
        lk_valid = 1'b1; lk_pc = 32'h40;
        #1;
        chk("rerst_hit", 32'(hit0), 32'h0);
        chk("rerst_target", target0, 32'h44);
        chk("rerst_lookups", sl0, 32'h0);
        chk("rerst_mispredicts", sm0, 32'h0);
        lk_valid = 1'b0;

        // Gshare sequence on dut1
        chk("gs_ghr0", 32'(ghr1), 32'h0);
        upd(32'h30, 1'b0, 1'b1, 32'h300, 4'h0);
        chk("gs_ghr_uncond", 32'(ghr1), 32'h0);
        upd(32'h40, 1'b1, 1'b1, 32'h80, 4'h5);
        chk("gs_ghr1", 32'(ghr1), 32'h1);
        upd(32'h40, 1'b1, 1'b1, 32'h80, 4'h5);
        chk("gs_ghr2", 32'(ghr1), 32'h3);
        upd(32'h40, 1'b1, 1'b1, 32'h80, 4'h5);
        chk("gs_ghr3", 32'(ghr1), 32'h7);
        upd(32'h40, 1'b1, 1'b1, 32'h80, 4'h5);
        chk("gs_ghr4", 32'(ghr1), 32'hf);
        look1("gs_pre40", 32'h40, 1'b1, 1'b0, 32'h80);
        look1("gs_pre30", 32'h30, 1'b1, 1'b0, 32'h300);
        upd(32'h40, 1'b1, 1'b1, 32'h80, 4'h3);
        chk("gs_ghr5", 32'(ghr1), 32'hf);
        look1("gs_post30", 32'h30, 1'b1, 1'b1, 32'h300);
        look1("gs_post40", 32'h40, 1'b1, 1'b0, 32'h80);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
